// File: rtl/mlp_train_sequencer.sv
// Stimulus-side sequencer for the MLP block: replays a small sample memory, strobes
// training after the combinational path settles, and reports per-epoch absolute loss.
module mlp_train_sequencer #(
  parameter int INPUTS        = 2,
  parameter int OUTPUTS       = 1,
  parameter int DEPTH         = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int EPOCH_W       = 16,
  parameter int SFP_W         = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_wr_en,
  input  logic [$clog2(DEPTH)-1:0]          i_wr_addr,
  input  logic [INPUTS-1:0][SFP_W-1:0]      i_wr_values,
  input  logic [OUTPUTS-1:0][SFP_W-1:0]     i_wr_expected,
  input  logic                              i_start,
  input  logic                              i_train_mode,
  input  logic [$clog2(DEPTH):0]            i_num_samples,
  input  logic [EPOCH_W-1:0]                i_num_epochs,
  input  logic                              i_abort,
  output logic [INPUTS-1:0][SFP_W-1:0]      o_mlp_values,
  output logic [OUTPUTS-1:0][SFP_W-1:0]     o_mlp_expected,
  output logic                              o_mlp_training,
  input  logic [OUTPUTS-1:0][SFP_W-1:0]     i_mlp_prediction,
  output logic                              o_busy,
  output logic                              o_pred_valid,
  output logic [$clog2(DEPTH)-1:0]          o_pred_index,
  output logic [OUTPUTS-1:0][SFP_W-1:0]     o_pred_out,
  output logic                              o_epoch_done,
  output logic [EPOCH_W-1:0]                o_epoch_index,
  output logic [SFP_W-1:0]                  o_epoch_loss,
  output logic                              o_run_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SFP_W-1:0] SFP_MAX = {1'b0, {(SFP_W-1){1'b1}}};
  localparam logic [SFP_W-1:0] SFP_MIN = {1'b1, {(SFP_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRESENT   = 3'd1,
    S_UPDATE    = 3'd2,
    S_EPOCH_END = 3'd3,
    S_FINISH    = 3'd4
  } state_t;

  // Saturating two's-complement add.
  function automatic logic [SFP_W-1:0] sfp_add(input logic [SFP_W-1:0] a, input logic [SFP_W-1:0] b);
    logic [SFP_W-1:0] s;
    s = a + b;
    if ((a[SFP_W-1] == b[SFP_W-1]) && (s[SFP_W-1] != a[SFP_W-1])) begin
      s = a[SFP_W-1] ? SFP_MIN : SFP_MAX;
    end else begin
      s = s;
    end
    return s;
  endfunction

  function automatic logic [SFP_W-1:0] sfp_sub(input logic [SFP_W-1:0] a, input logic [SFP_W-1:0] b);
    logic [SFP_W-1:0] d;
    d = a - b;
    if ((a[SFP_W-1] != b[SFP_W-1]) && (d[SFP_W-1] != a[SFP_W-1])) begin
      d = a[SFP_W-1] ? SFP_MIN : SFP_MAX;
    end else begin
      d = d;
    end
    return d;
  endfunction

  function automatic logic [SFP_W-1:0] sfp_abs(input logic [SFP_W-1:0] a);
    logic [SFP_W-1:0] r;
    if (a == SFP_MIN) begin
      r = SFP_MAX;
    end else if (a[SFP_W-1]) begin
      r = -a;
    end else begin
      r = a;
    end
    return r;
  endfunction

  state_t                          r_state;
  state_t                          w_next_state;
  logic [INPUTS-1:0][SFP_W-1:0]    r_mem_values   [DEPTH];
  logic [OUTPUTS-1:0][SFP_W-1:0]   r_mem_expected [DEPTH];
  logic [AW-1:0]                   r_idx;
  logic [AW-1:0]                   w_idx_next;
  logic [EPOCH_W-1:0]              r_epoch;
  logic [EPOCH_W-1:0]              w_epoch_next;
  logic [CW-1:0]                   r_settle_cnt;
  logic [CW-1:0]                   w_settle_next;
  logic [SFP_W-1:0]                r_acc;
  logic [SFP_W-1:0]                w_acc_next;
  logic [SFP_W-1:0]                w_err_sum;
  logic                            r_train_mode;
  logic [AW:0]                     r_num_samples;
  logic [EPOCH_W-1:0]              r_num_epochs;
  logic [INPUTS-1:0][SFP_W-1:0]    r_mlp_values;
  logic [OUTPUTS-1:0][SFP_W-1:0]   r_mlp_expected;
  logic                            r_training;
  logic                            r_busy;
  logic                            r_pred_valid;
  logic [AW-1:0]                   r_pred_index;
  logic [OUTPUTS-1:0][SFP_W-1:0]   r_pred_out;
  logic                            r_epoch_done;
  logic [EPOCH_W-1:0]              r_epoch_index;
  logic [SFP_W-1:0]                r_epoch_loss;
  logic                            r_run_done;
  logic                            w_start_ok;
  logic                            w_last_settle;
  logic                            w_last_sample;
  logic                            w_last_epoch;
  logic                            w_capture;
  logic                            w_load_sample;

  assign w_start_ok    = i_start && (i_num_samples != '0) && (i_num_samples <= (AW+1)'(DEPTH));
  assign w_last_settle = (r_settle_cnt == CW'(SETTLE_CYCLES - 1));
  assign w_last_sample = ({1'b0, r_idx} == (r_num_samples - (AW+1)'(1)));
  assign w_last_epoch  = (({1'b0, r_epoch} + (EPOCH_W+1)'(1)) == {1'b0, r_num_epochs});
  assign w_capture     = (r_state == S_PRESENT) && w_last_settle && !i_abort;
  assign w_acc_next    = w_capture ? sfp_add(r_acc, w_err_sum) : r_acc;

  // Sample memory write port; contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if ((r_state == S_IDLE) && i_wr_en) begin
      r_mem_values[i_wr_addr]   <= i_wr_values;
      r_mem_expected[i_wr_addr] <= i_wr_expected;
    end
  end

  // Summed absolute error of the presented sample against the MLP prediction.
  always_comb begin
    w_err_sum = '0;
    for (int k = 0; k < OUTPUTS; k++) begin
      w_err_sum = sfp_add(w_err_sum, sfp_abs(sfp_sub(r_mlp_expected[k], i_mlp_prediction[k])));
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; abort beats everything except reset.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_abort) begin
          w_next_state = S_IDLE;
        end else if (w_start_ok) begin
          w_next_state = (i_train_mode && (i_num_epochs == '0)) ? S_FINISH : S_PRESENT;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_PRESENT: begin
        if (i_abort) begin
          w_next_state = S_IDLE;
        end else if (!w_last_settle) begin
          w_next_state = S_PRESENT;
        end else if (r_train_mode) begin
          w_next_state = S_UPDATE;
        end else begin
          w_next_state = w_last_sample ? S_EPOCH_END : S_PRESENT;
        end
      end
      S_UPDATE: begin
        if (i_abort) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = w_last_sample ? S_EPOCH_END : S_PRESENT;
        end
      end
      S_EPOCH_END: begin
        if (i_abort) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = (!r_train_mode || w_last_epoch) ? S_FINISH : S_PRESENT;
        end
      end
      S_FINISH: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Output/datapath steering: next index, epoch, settle count and sample reload.
  always_comb begin
    w_idx_next    = r_idx;
    w_epoch_next  = r_epoch;
    w_settle_next = '0;
    case (r_state)
      S_IDLE: begin
        w_idx_next   = '0;
        w_epoch_next = '0;
      end
      S_PRESENT: begin
        if (!w_last_settle) begin
          w_settle_next = r_settle_cnt + CW'(1);
        end else if (!r_train_mode && !w_last_sample) begin
          w_idx_next = r_idx + AW'(1);
        end else begin
          w_idx_next = r_idx;
        end
      end
      S_UPDATE: begin
        if (!w_last_sample) begin
          w_idx_next = r_idx + AW'(1);
        end else begin
          w_idx_next = r_idx;
        end
      end
      S_EPOCH_END: begin
        w_idx_next = '0;
        if (w_next_state == S_PRESENT) begin
          w_epoch_next = r_epoch + EPOCH_W'(1);
        end else begin
          w_epoch_next = r_epoch;
        end
      end
      default: begin
        w_idx_next = r_idx;
      end
    endcase
    w_load_sample = (w_next_state == S_PRESENT) && ((r_state != S_PRESENT) || w_last_settle);
  end

  // Run context, accumulator and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx          <= '0;
      r_epoch        <= '0;
      r_settle_cnt   <= '0;
      r_acc          <= '0;
      r_train_mode   <= 1'b0;
      r_num_samples  <= '0;
      r_num_epochs   <= '0;
      r_mlp_values   <= '0;
      r_mlp_expected <= '0;
      r_training     <= 1'b0;
      r_busy         <= 1'b0;
      r_pred_valid   <= 1'b0;
      r_pred_index   <= '0;
      r_pred_out     <= '0;
      r_epoch_done   <= 1'b0;
      r_epoch_index  <= '0;
      r_epoch_loss   <= '0;
      r_run_done     <= 1'b0;
    end else begin
      r_idx        <= w_idx_next;
      r_epoch      <= w_epoch_next;
      r_settle_cnt <= w_settle_next;
      r_acc        <= ((r_state == S_IDLE) || (r_state == S_EPOCH_END)) ? '0 : w_acc_next;
      if ((r_state == S_IDLE) && (w_next_state != S_IDLE)) begin
        r_train_mode  <= i_train_mode;
        r_num_samples <= i_num_samples;
        r_num_epochs  <= i_num_epochs;
      end
      if (w_load_sample) begin
        r_mlp_values   <= r_mem_values[w_idx_next];
        r_mlp_expected <= r_mem_expected[w_idx_next];
      end
      r_busy       <= (w_next_state != S_IDLE);
      r_training   <= (w_next_state == S_UPDATE);
      r_pred_valid <= w_capture && !r_train_mode;
      if (w_capture && !r_train_mode) begin
        r_pred_index <= r_idx;
        r_pred_out   <= i_mlp_prediction;
      end
      r_epoch_done <= (w_next_state == S_EPOCH_END);
      // Loss includes the sample captured on this same edge (inference path).
      if (w_next_state == S_EPOCH_END) begin
        r_epoch_index <= r_epoch;
        r_epoch_loss  <= w_acc_next;
      end
      r_run_done <= (w_next_state == S_FINISH);
    end
  end

  assign o_mlp_values   = r_mlp_values;
  assign o_mlp_expected = r_mlp_expected;
  assign o_mlp_training = r_training && !i_abort;
  assign o_busy         = r_busy;
  assign o_pred_valid   = r_pred_valid;
  assign o_pred_index   = r_pred_index;
  assign o_pred_out     = r_pred_out;
  assign o_epoch_done   = r_epoch_done;
  assign o_epoch_index  = r_epoch_index;
  assign o_epoch_loss   = r_epoch_loss;
  assign o_run_done     = r_run_done;

endmodule

// File: tb/tb_mlp_train_sequencer.sv
// Directed bench for mlp_train_sequencer: a timeline model built from the run
// parameters predicts every output each cycle; literal values pin the model.
module tb_mlp_train_sequencer;
  localparam int S = 2;
  localparam int DEPTH = 4;
  localparam int L = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, wr_en, start, train_mode, abort;
  logic [1:0]        wr_addr;
  logic [1:0][15:0]  wr_values;
  logic [0:0][15:0]  wr_expected;
  logic [2:0]        num_samples;
  logic [15:0]       num_epochs;
  logic [1:0][15:0]  mlp_values;
  logic [0:0][15:0]  mlp_expected;
  logic              mlp_training;
  logic [0:0][15:0]  mlp_prediction;
  logic              busy, pred_valid, epoch_done, run_done;
  logic [1:0]        pred_index;
  logic [0:0][15:0]  pred_out;
  logic [15:0]       epoch_index, epoch_loss;

  // Stand-in MLP: either a fixed prediction or a copy of the first input.
  logic              pred_mode;
  logic [15:0]       pred_const;
  assign mlp_prediction[0] = pred_mode ? mlp_values[0] : pred_const;

  mlp_train_sequencer dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_values(wr_values), .i_wr_expected(wr_expected), .i_start(start),
    .i_train_mode(train_mode), .i_num_samples(num_samples), .i_num_epochs(num_epochs),
    .i_abort(abort), .o_mlp_values(mlp_values), .o_mlp_expected(mlp_expected),
    .o_mlp_training(mlp_training), .i_mlp_prediction(mlp_prediction), .o_busy(busy),
    .o_pred_valid(pred_valid), .o_pred_index(pred_index), .o_pred_out(pred_out),
    .o_epoch_done(epoch_done), .o_epoch_index(epoch_index), .o_epoch_loss(epoch_loss),
    .o_run_done(run_done)
  );

  int n_vec = 0;
  int n_fail = 0;
  int mv0 [DEPTH];
  int mv1 [DEPTH];
  int me  [DEPTH];
  int m_busy [L];
  int m_train [L];
  int m_pv [L];
  int m_pvi [L];
  int m_pvo [L];
  int m_ed [L];
  int m_edi [L];
  int m_edl [L];
  int m_rd [L];
  int m_pres [L];
  int m_hidx [L];
  int m_hloss [L];
  int m_end;
  int h_idx = 0;
  int h_loss = 0;
  int c_pv, c_tr, c_busy, c_ed, c_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sval(input int u);
    return (u >= 32768) ? u - 65536 : u;
  endfunction

  function automatic int pred_of(input int i);
    return pred_mode ? mv0[i] : int'(pred_const);
  endfunction

  // Expected per-cycle behaviour of one run (cycle 1 = first cycle after start edge).
  task automatic build(input int train, input int ns, input int ne, input int abort_at);
    int t, acc, p, d, ep;
    for (int k = 0; k < L; k++) begin
      m_busy[k] = 0; m_train[k] = 0; m_pv[k] = 0; m_pvi[k] = 0; m_pvo[k] = 0;
      m_ed[k] = 0; m_edi[k] = 0; m_edl[k] = 0; m_rd[k] = 0; m_pres[k] = -1;
    end
    t = 1;
    if (ns >= 1 && ns <= DEPTH && abort_at != 0) begin
      ep = train ? ne : 1;
      for (int e = 0; e < ep; e++) begin
        acc = 0;
        for (int i = 0; i < ns; i++) begin
          for (int c = 0; c < S; c++) m_pres[t + c] = i;
          p = pred_of(i);
          d = sval(me[i]) - sval(p);
          if (d < 0) d = -d;
          if (d > 32767) d = 32767;
          acc = acc + d;
          if (acc > 32767) acc = 32767;
          t += S;
          if (train != 0) begin
            m_pres[t] = i; m_train[t] = 1; t++;
          end else begin
            m_pv[t] = 1; m_pvi[t] = i; m_pvo[t] = p;
          end
        end
        m_ed[t] = 1; m_edi[t] = e; m_edl[t] = acc; t++;
      end
      m_rd[t] = 1; t++;
      for (int k = 1; k < t; k++) m_busy[k] = 1;
    end
    m_end = t;
    if (abort_at > 0 && abort_at < m_end) begin
      m_train[abort_at] = 0;
      for (int k = abort_at + 1; k < L; k++) begin
        m_busy[k] = 0; m_train[k] = 0; m_pv[k] = 0; m_ed[k] = 0; m_rd[k] = 0; m_pres[k] = -1;
      end
      m_end = abort_at + 1;
    end
    for (int k = 1; k < L; k++) begin
      if (m_ed[k] != 0) begin
        h_idx = m_edi[k]; h_loss = m_edl[k];
      end
      m_hidx[k] = h_idx; m_hloss[k] = h_loss;
    end
  endtask

  task automatic compare(input int t);
    check("busy", busy, m_busy[t]);
    check("mlp_training", mlp_training, m_train[t]);
    check("pred_valid", pred_valid, m_pv[t]);
    check("epoch_done", epoch_done, m_ed[t]);
    check("run_done", run_done, m_rd[t]);
    if (m_pv[t] != 0) begin
      check("pred_index", pred_index, m_pvi[t]);
      check("pred_out", pred_out[0], m_pvo[t]);
    end
    check("epoch_index", epoch_index, m_hidx[t]);
    check("epoch_loss", epoch_loss, m_hloss[t]);
    if (m_pres[t] >= 0) begin
      check("mlp_values0", mlp_values[0], mv0[m_pres[t]]);
      check("mlp_values1", mlp_values[1], mv1[m_pres[t]]);
      check("mlp_expected", mlp_expected[0], me[m_pres[t]]);
    end
    c_pv += int'(pred_valid); c_tr += int'(mlp_training); c_busy += int'(busy);
    c_ed += int'(epoch_done); c_rd += int'(run_done);
  endtask

  // abort_at: -1 none, 0 together with start, else cycle index; wr_at: cycle of a stray write.
  task automatic run(input int train, input int ns, input int ne, input int abort_at, input int wr_at);
    build(train, ns, ne, abort_at);
    @(posedge clk); #1;
    start = 1'b1; train_mode = train[0]; num_samples = ns[2:0]; num_epochs = ne[15:0];
    abort = (abort_at == 0);
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    c_pv = 0; c_tr = 0; c_busy = 0; c_ed = 0; c_rd = 0;
    for (int t = 1; t <= m_end + 1; t++) begin
      if (t == abort_at) abort = 1'b1;
      if (t == wr_at) begin
        wr_en = 1'b1; wr_addr = 2'd1;
        wr_values[0] = 16'h1234; wr_values[1] = 16'h1234; wr_expected[0] = 16'h1234;
      end
      @(negedge clk);
      compare(t);
      @(posedge clk); #1;
      abort = 1'b0; wr_en = 1'b0;
    end
  endtask

  task automatic write(input int a, input int v0, input int v1, input int e);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = a[1:0];
    wr_values[0] = v0[15:0]; wr_values[1] = v1[15:0]; wr_expected[0] = e[15:0];
    mv0[a] = v0; mv1[a] = v1; me[a] = e;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic load_basic();
    for (int k = 0; k < DEPTH; k++) write(k, k * 128, 256 + k, 256);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; start = 1'b0; train_mode = 1'b0; abort = 1'b0;
    wr_addr = 2'd0; wr_values = '0; wr_expected = '0; num_samples = 3'd0; num_epochs = 16'd0;
    pred_mode = 1'b0; pred_const = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 32'd0);
    check("rst_training", mlp_training, 32'd0);
    check("rst_values", mlp_values, 32'd0);
    check("rst_expected", mlp_expected[0], 32'd0);
    check("rst_strobes", {pred_valid, epoch_done, run_done}, 32'd0);
    check("rst_loss", epoch_loss, 32'd0);
    rst = 1'b0;

    // Inference: expected ONE, prediction 0.5 -> four errors of 0.5.
    load_basic();
    pred_mode = 1'b0; pred_const = 16'h0080;
    run(0, 4, 0, -1, -1);
    check("inf_pv_count", c_pv, 32'd4);
    check("inf_train_count", c_tr, 32'd0);
    check("inf_model_loss", h_loss, 32'h0200);
    check("inf_loss", epoch_loss, 32'h0200);
    check("inf_done_counts", {c_ed[7:0], c_rd[7:0]}, 32'h0101);

    // Training, prediction = first input: per-epoch loss 1 + 0.5 + 0 = 1.5.
    pred_mode = 1'b1;
    run(1, 3, 2, -1, -1);
    check("trn_train_count", c_tr, 32'd6);
    check("trn_busy_cycles", c_busy, 32'd21);
    check("trn_model_loss", h_loss, 32'h0180);
    check("trn_loss", epoch_loss, 32'h0180);
    check("trn_epoch_index", epoch_index, 32'd1);
    check("trn_ed_count", c_ed, 32'd2);

    // Saturation: four errors of 0x7000 must clamp at 0x7FFF.
    for (int k = 0; k < DEPTH; k++) write(k, 0, 0, 16'h7000);
    pred_mode = 1'b0; pred_const = 16'h0000;
    run(0, 4, 0, -1, -1);
    check("sat_loss", epoch_loss, 32'h7FFF);

    // Abort during epoch 1 on an UPDATE cycle, with a stray write mid-run.
    load_basic();
    pred_mode = 1'b1;
    run(1, 4, 3, 19, 5);
    check("abt_loss_held", epoch_loss, 32'h0200);
    check("abt_ed_count", c_ed, 32'd1);
    check("abt_rd_count", c_rd, 32'd0);
    pred_mode = 1'b0; pred_const = 16'h0080;
    run(0, 4, 0, -1, -1);

    // Illegal starts, abort beating start, and a zero-epoch training run.
    run(0, 0, 1, -1, -1);
    check("ill_zero_busy", c_busy, 32'd0);
    run(1, 5, 1, -1, -1);
    check("ill_over_busy", c_busy, 32'd0);
    run(1, 3, 1, 0, -1);
    check("abort_start_busy", c_busy, 32'd0);
    run(1, 3, 0, -1, -1);
    check("zero_ep_run_done", c_rd, 32'd1);
    check("zero_ep_train", c_tr, 32'd0);
    check("zero_ep_busy", c_busy, 32'd1);

    // Reset landing on an UPDATE cycle.
    pred_mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; train_mode = 1'b1; num_samples = 3'd2; num_epochs = 16'd1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("upd_training", mlp_training, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_upd_training", mlp_training, 32'd0);
    check("rst_upd_busy", busy, 32'd0);
    check("rst_upd_loss", epoch_loss, 32'd0);
    check("rst_upd_values", mlp_values, 32'd0);
    rst = 1'b0;
    h_idx = 0; h_loss = 0;
    pred_mode = 1'b0; pred_const = 16'h0080;
    run(0, 2, 0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/mlp_train_sequencer.md
Name: mlp_train_sequencer

Overview:
- Drives the MLP block from the stimulus side: sample sequencing, training strobes and loss collection.
- Holds a small on-chip sample memory of input vectors and expected outputs.
- Presents each sample to the MLP, waits for the combinational forward/backward path to settle, then pulses training for exactly one cycle.
- Accumulates per-epoch absolute error. In inference mode it streams predictions out instead of training.

Parameters:
- INPUTS, 2, sfp elements per input vector; matches MLP inputs.
- OUTPUTS, 1, sfp elements per expected/prediction vector; matches MLP outputs.
- DEPTH, 4, sample memory entries; power of two, ≥2.
- SETTLE_CYCLES, 2, cycles a sample is held with training low before the update/capture cycle; ≥1.
- EPOCH_W, 16, width of epoch counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wr_en  in  1  sample memory write strobe; honoured only in IDLE
- wr_addr  in  $clog2(DEPTH)  write address
- wr_values  in  sfp[INPUTS]  input vector to store
- wr_expected  in  sfp[OUTPUTS]  expected vector to store
- start  in  1  single-cycle run request; honoured only in IDLE
- train_mode  in  1  sampled at start; 1 = train, 0 = inference pass
- num_samples  in  $clog2(DEPTH)+1  sampled at start; range 1..DEPTH
- num_epochs  in  EPOCH_W  sampled at start; ignored in inference mode
- abort  in  1  stop run, return to IDLE
- mlp_values  out  sfp[INPUTS]  to MLP values
- mlp_expected  out  sfp[OUTPUTS]  to MLP expected
- mlp_training  out  1  to MLP training
- mlp_prediction  in  sfp[OUTPUTS]  from MLP prediction
- busy  out  1  high in any state other than IDLE
- pred_valid  out  1  one-cycle strobe per sample, inference mode only
- pred_index  out  $clog2(DEPTH)  sample index of pred_out
- pred_out  out  sfp[OUTPUTS]  captured prediction
- epoch_done  out  1  one-cycle strobe at end of each epoch
- epoch_index  out  EPOCH_W  index of the completed epoch, 0-based
- epoch_loss  out  sfp  summed absolute error of the completed epoch
- run_done  out  1  one-cycle strobe when the run completes normally

Behaviour:
- Reset: FSM to IDLE. All outputs 0, including mlp_values, mlp_expected, mlp_training, busy, strobes and epoch_loss. Counters and accumulator 0. Sample memory contents are not reset.
- Memory: one write per cycle. Written data is readable from the next cycle. wr_en outside IDLE is ignored.
- start in IDLE with num_samples = 0 or > DEPTH: ignored, FSM stays in IDLE.
- start in IDLE with train_mode = 1 and num_epochs = 0: run_done pulses the next cycle with no sample presented.
- States: IDLE, PRESENT, UPDATE, EPOCH_END, FINISH.
- IDLE → PRESENT on valid start. Sample index and epoch counter clear to 0; the accumulator clears.
- PRESENT:
  - mlp_values and mlp_expected are registered from memory[idx]; mlp_training = 0.
  - Stay SETTLE_CYCLES cycles.
  - On the last cycle, capture mlp_prediction. Add the sum over OUTPUTS of |expected − prediction| into the accumulator.
  - Arithmetic uses the FixedPoint sfp_add/sfp_sub helpers. The accumulator saturates at the most positive sfp value and never wraps.
  - Train mode: next state is UPDATE.
  - Inference mode: pred_valid pulses for one cycle with pred_index = idx and pred_out = captured prediction. Then advance the index, or go to EPOCH_END after the last sample.
- UPDATE: mlp_training = 1 for exactly one cycle; mlp_values and mlp_expected are unchanged. Then advance idx and go to PRESENT. After the last sample (idx = num_samples − 1) go to EPOCH_END.
- Per-sample latency: SETTLE_CYCLES + 1 cycles in train mode, SETTLE_CYCLES in inference mode.
- EPOCH_END (1 cycle):
  - epoch_done pulses; epoch_index and epoch_loss are registered and held until the next epoch_done or reset.
  - The accumulator clears and idx resets to 0.
  - If epoch + 1 = num_epochs, or in inference mode, go to FINISH; otherwise increment epoch and go to PRESENT.
- FINISH (1 cycle): run_done pulses, mlp_training = 0, then go to IDLE.
- abort in any non-IDLE state:
  - Next state is IDLE; mlp_training is forced to 0 in the same cycle abort is high.
  - No epoch_done or run_done is issued; epoch_loss keeps its last value.
- abort and start together in IDLE: abort wins and start is ignored.
- rst mid-run behaves as reset above and takes priority over everything.
- mlp_training is never high for two consecutive cycles.
- mlp_values and mlp_expected change only on entry to PRESENT.

Test Plan:
- Reset → all outputs 0, busy = 0. Assert rst during an UPDATE cycle → mlp_training = 0 next cycle and FSM in IDLE.
- Inference run: write 4 samples, expected = ONE, MLP prediction tied to 0.5; start with train_mode = 0, num_samples = 4, SETTLE_CYCLES = 2.
  - pred_valid pulses 4 times at 2-cycle spacing, pred_index 0..3.
  - One epoch_done with epoch_loss = 2.0, then run_done; mlp_training is never high.
- Train run: num_samples = 3, num_epochs = 2.
  - Exactly 6 mlp_training pulses, each preceded by 2 PRESENT cycles.
  - epoch_done pulses with epoch_index 0 then 1, then run_done; busy is high for 3·3·2 + 2·1 + 1 = 21 cycles.
- Saturation: 4 samples with |error| near the positive sfp limit → epoch_loss equals the most positive sfp value and does not wrap negative.
- Abort during the second epoch → FSM in IDLE next cycle, no further epoch_done or run_done, epoch_loss holds the epoch-0 value. A wr_en issued during the run did not alter memory.
- Illegal start (num_samples = 0, and num_samples = DEPTH + 1) → busy stays 0. num_epochs = 0 in train mode → run_done one cycle after start, zero training pulses.
